// File: rtl/edge_pipeline_sequencer.sv
// Sequencer for the edge-processing chain: launches enabled stages in order,
// steers the shared BRAM port owner, gates VGA output and watches for hung stages.
module edge_pipeline_sequencer #(
    parameter int unsigned TIMEOUT = 4_000_000,
    parameter int unsigned CNT_W   = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       abort,
    input  logic [3:0] stage_en,
    input  logic [3:0] stage_done,
    output logic [3:0] stage_start,
    output logic [2:0] port_sel,
    output logic       busy,
    output logic       done,
    output logic       vga_enable,
    output logic       error,
    output logic [1:0] err_stage
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WD_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       r_cur;
    logic [3:0]       r_mask;
    logic [3:0]       r_done_q;
    logic [3:0]       r_start;
    logic [2:0]       r_port_sel;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [1:0]       r_err_stage;
    logic [CNT_W-1:0] r_wd;

    logic       w_first_vld;
    logic [1:0] w_first;
    logic       w_next_vld;
    logic [1:0] w_next;
    logic       w_complete;
    logic       w_timeout;

    // Lowest enabled stage for a new run, and next enabled stage above r_cur.
    always_comb begin
        w_first_vld = 1'b0;
        w_first     = '0;
        w_next_vld  = 1'b0;
        w_next      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (stage_en[i] && !w_first_vld) begin
                w_first_vld = 1'b1;
                w_first     = 2'(i);
            end
            if (r_mask[i] && (i > {30'b0, r_cur}) && !w_next_vld) begin
                w_next_vld = 1'b1;
                w_next     = 2'(i);
            end
        end
    end

    assign w_complete = stage_done[r_cur] & ~r_done_q[r_cur];
    assign w_timeout  = (r_wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_mask      <= '0;
            r_done_q    <= '1;
            r_start     <= '0;
            r_port_sel  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_stage <= '0;
            r_wd        <= '0;
        end else begin
            r_done_q <= stage_done;
            r_start  <= '0;
            if (abort) begin
                r_state    <= S_IDLE;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_busy     <= 1'b0;
                r_port_sel <= '0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_wd <= r_wd + WD_ONE;
                        if (w_timeout) begin
                            r_state     <= S_ERROR;
                            r_error     <= 1'b1;
                            r_err_stage <= r_cur;
                            r_port_sel  <= '0;
                            r_busy      <= 1'b0;
                        end else if (w_complete) begin
                            if (w_next_vld) begin
                                r_cur      <= w_next;
                                r_start    <= 4'b0001 << w_next;
                                r_port_sel <= {1'b0, w_next} + 3'd1;
                                r_wd       <= '0;
                            end else begin
                                r_state    <= S_DONE;
                                r_done     <= 1'b1;
                                r_busy     <= 1'b0;
                                r_port_sel <= '0;
                            end
                        end
                    end
                    S_IDLE, S_DONE: begin
                        if (go) begin
                            r_mask <= stage_en;
                            if (w_first_vld) begin
                                r_state    <= S_RUN;
                                r_cur      <= w_first;
                                r_start    <= 4'b0001 << w_first;
                                r_port_sel <= {1'b0, w_first} + 3'd1;
                                r_busy     <= 1'b1;
                                r_done     <= 1'b0;
                                r_wd       <= '0;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // ERROR holds until abort or reset
                    end
                endcase
            end
        end
    end

    assign stage_start = r_start;
    assign port_sel    = r_port_sel;
    assign busy        = r_busy;
    assign done        = r_done;
    assign vga_enable  = r_done;
    assign error       = r_error;
    assign err_stage   = r_err_stage;

endmodule

// File: tb/tb_edge_pipeline_sequencer.sv
// Directed-vector bench for edge_pipeline_sequencer with hand-computed expectations.
module tb_edge_pipeline_sequencer;

    logic       clk;
    logic       rst;
    logic       go;
    logic       abort;
    logic [3:0] stage_en;
    logic [3:0] stage_done;
    logic [3:0] stage_start;
    logic [2:0] port_sel;
    logic       busy;
    logic       done;
    logic       vga_enable;
    logic       error;
    logic [1:0] err_stage;

    int n_vec;
    int n_err;

    edge_pipeline_sequencer #(
        .TIMEOUT (16),
        .CNT_W   (5)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .abort       (abort),
        .stage_en    (stage_en),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .port_sel    (port_sel),
        .busy        (busy),
        .done        (done),
        .vga_enable  (vga_enable),
        .error       (error),
        .err_stage   (err_stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start"}, stage_start, 0);
        check({tag, "_ps"}, port_sel, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_vga"}, vga_enable, 0);
        check({tag, "_err"}, error, 0);
        check({tag, "_errst"}, err_stage, 0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        go         = 1'b0;
        abort      = 1'b0;
        stage_en   = 4'h0;
        stage_done = 4'h0;
        tick;
        tick;
        check_idle_outputs("rst");
        rst = 1'b0;
        tick;

        // Full chain: each done rises 10 cycles after its start.
        stage_en = 4'hF;
        go = 1'b1;
        tick;
        go = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("fc_start", stage_start, 32'd1 << k);
            check("fc_ps", port_sel, k + 1);
            check("fc_busy", busy, 1);
            check("fc_done0", done, 0);
            tick;
            check("fc_pulse", stage_start, 0);
            repeat (9) tick;
            check("fc_ps_hold", port_sel, k + 1);
            stage_done[k] = 1'b1;
            tick;
        end
        check("fc_done", done, 1);
        check("fc_vga", vga_enable, 1);
        check("fc_busy_end", busy, 0);
        check("fc_ps_end", port_sel, 0);
        check("fc_start_end", stage_start, 0);
        stage_done = 4'h0;
        tick;

        // Skip mask 1010 from DONE; mask change after go must not matter.
        stage_en = 4'b1010;
        go = 1'b1;
        tick;
        go = 1'b0;
        stage_en = 4'hF;
        check("sk_done_drop", done, 0);
        check("sk_start1", stage_start, 4'b0010);
        check("sk_ps1", port_sel, 2);
        repeat (10) tick;
        check("sk_nostart", stage_start, 0);
        stage_done[1] = 1'b1;
        tick;
        check("sk_start3", stage_start, 4'b1000);
        check("sk_ps3", port_sel, 4);
        repeat (10) tick;
        stage_done[3] = 1'b1;
        tick;
        check("sk_done", done, 1);
        check("sk_ps_end", port_sel, 0);
        stage_done = 4'h0;

        // Mask 0 from IDLE: done one cycle after go, no start.
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("ab_done_clr", done, 0);
        stage_en = 4'h0;
        go = 1'b1;
        tick;
        go = 1'b0;
        check("m0_done", done, 1);
        check("m0_start", stage_start, 0);
        check("m0_busy", busy, 0);

        // Stale done: sobel done already high before go.
        stage_done = 4'b0001;
        tick;
        stage_en = 4'b0001;
        go = 1'b1;
        tick;
        go = 1'b0;
        check("st_start", stage_start, 4'b0001);
        check("st_busy0", busy, 1);
        repeat (5) tick;
        check("st_busy5", busy, 1);
        check("st_noadv", done, 0);
        check("st_ps", port_sel, 1);
        stage_done[0] = 1'b0;
        tick;
        check("st_busy6", busy, 1);
        tick;
        check("st_busy7", busy, 1);
        stage_done[0] = 1'b1;
        tick;
        check("st_done", done, 1);
        check("st_busy_end", busy, 0);
        stage_done = 4'h0;

        // Timeout: isolate never completes.
        stage_en = 4'b0100;
        go = 1'b1;
        tick;
        go = 1'b0;
        check("to_start", stage_start, 4'b0100);
        check("to_ps", port_sel, 3);
        repeat (15) tick;
        check("to_err_early", error, 0);
        check("to_busy15", busy, 1);
        tick;
        check("to_err", error, 1);
        check("to_errst", err_stage, 2);
        check("to_ps0", port_sel, 0);
        stage_en = 4'b0001;
        go = 1'b1;
        tick;
        go = 1'b0;
        check("to_go_ign", stage_start, 0);
        check("to_err_hold", error, 1);
        check("to_ps_hold", port_sel, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("to_abort_err", error, 0);
        check("to_abort_done", done, 0);

        // Abort mid-erode, then go and abort together in IDLE.
        stage_en = 4'b0010;
        go = 1'b1;
        tick;
        go = 1'b0;
        check("am_ps", port_sel, 2);
        repeat (3) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("am_ps0", port_sel, 0);
        check("am_busy", busy, 0);
        check("am_start", stage_start, 0);
        go = 1'b1;
        abort = 1'b1;
        tick;
        go = 1'b0;
        abort = 1'b0;
        check("ga_start", stage_start, 0);
        check("ga_ps", port_sel, 0);
        check("ga_busy", busy, 0);
        tick;
        check("ga_idle", busy, 0);

        // Reset mid-run, then a normal run.
        stage_en = 4'hF;
        go = 1'b1;
        tick;
        go = 1'b0;
        repeat (3) tick;
        check("rr_busy", busy, 1);
        rst = 1'b1;
        tick;
        check_idle_outputs("rr");
        rst = 1'b0;
        stage_en = 4'b0001;
        go = 1'b1;
        tick;
        go = 1'b0;
        check("rr_start", stage_start, 4'b0001);
        check("rr_ps", port_sel, 1);
        tick;
        stage_done[0] = 1'b1;
        tick;
        check("rr_done", done, 1);
        check("rr_ps_end", port_sel, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/edge_pipeline_sequencer.md
# edge_pipeline_sequencer

Central controller for the edge-processing chain (sobel → edge thinning → single-edge isolation → color contour). It replaces the ad-hoc done-chained priority muxing in the image processing top level: it launches each enabled stage in order with a one-cycle start pulse, waits for that stage's done, and drives a single port-select code that steers the shared edge BRAM ports and the frame-buffer read port. It also gates the VGA output and runs a per-stage watchdog. It sits in the `CLK_100M` domain beside the stage modules.

## Interface
Parameters:
- `TIMEOUT`, 4_000_000: maximum cycles a stage may run before it is declared hung.
- `CNT_W`, 22: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock (`CLK_100M`).
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  single-cycle request to run the chain.
- `abort`  in  1  forces a return to idle; also clears an error.
- `stage_en`  in  4  stage enable mask: [0] sobel, [1] erode, [2] isolate, [3] color.
- `stage_done`  in  4  done levels from the stages, same bit order.
- `stage_start`  out  4  one-hot, single-cycle start pulses.
- `port_sel`  out  3  BRAM port owner: 0 = VGA/idle, 1 = sobel, 2 = erode, 3 = isolate, 4 = color.
- `busy`  out  1  high while any stage is running.
- `done`  out  1  chain complete; held high until the next accepted `go`.
- `vga_enable`  out  1  equals `done`; blanks RGB when low.
- `error`  out  1  watchdog fired.
- `err_stage`  out  2  index of the stage that timed out.

## Operation
- States: IDLE, RUN, DONE, ERROR. `cur` (2 bits) holds the active stage index while in RUN.
- Reset values: state IDLE, `stage_start` 0, `port_sel` 0, `busy` 0, `done` 0, `vga_enable` 0, `error` 0, `err_stage` 0, watchdog 0, `done_q` 4'b1111.
- The `stage_en` mask is latched when `go` is accepted. Later changes to `stage_en` have no effect until the next accepted `go`.
- `go` is accepted only in IDLE or DONE. It is ignored in RUN and in ERROR.
- On acceptance, the sequencer selects the lowest enabled stage. If the mask is 0, it goes straight to DONE.
- Stage completion is the rising edge of `stage_done[cur]`, detected as `stage_done[cur] & ~done_q[cur]`. `done_q` registers `stage_done` every cycle.
  - A done line that is already high at start is ignored until it falls and rises again.
  - Done bits of non-active stages are ignored.
- On completion, the sequencer advances to the next higher enabled stage. If none remains, it enters DONE. Disabled stages are skipped in zero cycles.
- Watchdog:
  - Cleared on every stage start and incremented each cycle in RUN.
  - When the counter reaches TIMEOUT−1 without completion, the sequencer enters ERROR, sets `error`=1 and `err_stage`=`cur`, and sets `port_sel`=0.
- `abort` (any state) → IDLE. It clears `done`, `error`, `busy` and `port_sel`, and no start pulse is issued.
- Priority: `rst` > `abort` > watchdog > completion > `go`.

## Timing
- `go` sampled at cycle t → at t+1: state RUN, `stage_start[k]`=1 for exactly one cycle, `port_sel`=k+1, `busy`=1, `done`=0.
- Completion edge sampled at cycle u (u ≥ start cycle + 1):
  - If another stage is enabled, at u+1 its start pulse is issued and `port_sel` is updated in the same cycle.
  - Otherwise, at u+1: DONE, `done`=`vga_enable`=1, `busy`=0, `port_sel`=0.
- Mask 0: `go` at t → `done`=1 at t+1.
- `port_sel` never leaves the active stage's code while that stage runs. It changes only on the cycles listed above.
- Timeout: a stage started at s with no completion → `error`=1 at s+TIMEOUT.
- Re-`go` from DONE: `done` drops at t+1, at the same cycle as the new start pulse.

## Test plan
- Full chain: mask 4'b1111; each `stage_done` rises 10 cycles after its start → start pulses at t+1, t+12, t+23, t+34; `done`=1 at t+45; `port_sel` sequence 1,2,3,4,0.
- Skip: mask 4'b1010 → only erode and color start; `port_sel` sequence 2,4,0; mask 0 → `done` at t+1 with no start pulse.
- Stale done: `stage_done[0]` held high before `go` → no advance until it falls and rises; `busy` stays 1 throughout.
- Timeout with TIMEOUT=16: isolate never completes → `error`=1, `err_stage`=2 exactly 16 cycles after its start; `go` is then ignored; `abort` returns to IDLE with `error`=0.
- Abort mid-erode, plus `go` and `abort` in the same cycle in IDLE → IDLE, `port_sel`=0, no start pulse.
- `rst` asserted mid-RUN → all outputs at reset values on the next cycle; a later `go` runs the chain normally.
